// File: rtl/day5_pkg.sv
// Shared constants and FSM encoding for the day-5 range loader and solver.
package day5_pkg;

   localparam int unsigned WIDTH = 50;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_DASH = 8'h2D;
   localparam logic [7:0] CH_LF   = 8'h0A;
   localparam logic [7:0] CH_CR   = 8'h0D;

   typedef enum logic [2:0] {
      IDLE,
      P_LO,
      P_HI,
      EMIT,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/day_5_range_loader_dec_accum.sv
// Decimal accumulator: value = value*10 + digit with a sticky overflow flag.
module dec_accum #(
   parameter int unsigned WIDTH = day5_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load_digit,
   input  logic [3:0]       digit,
   output logic [WIDTH-1:0] value,
   output logic             ovf
);

   localparam int unsigned EXT_W = WIDTH + 4;

   logic [EXT_W-1:0] ext_c;
   logic [EXT_W-1:0] next_c;

   // x*10 as (x<<3)+(x<<1); the top 4 bits catch any result >= 2^WIDTH
   always_comb begin
      ext_c  = EXT_W'(value);
      next_c = (ext_c << 3) + (ext_c << 1) + EXT_W'(digit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (clear) begin
         value <= '0;
         ovf   <= 1'b0;
      end else if (load_digit) begin
         value <= next_c[WIDTH-1:0];
         if (next_c[EXT_W-1:WIDTH] != 4'd0) ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/day_5_range_loader.sv
// Streaming ASCII parser for the "a-b\n" ranges section; emits one record per line.
module day_5_range_loader #(
   parameter int unsigned WIDTH      = day5_pkg::WIDTH,
   parameter int unsigned MAX_RANGES = 182,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             rng_valid,
   output logic [WIDTH-1:0] rng_start,
   output logic [WIDTH-1:0] rng_end,
   output logic [CNT_W-1:0] rng_index,
   input  logic             rng_ready,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] count
);

   import day5_pkg::*;

   state_t state;
   logic   digit_seen;
   logic   lo_ovf;
   logic   hi_ovf;

   logic is_digit_c, is_dash_c, is_lf_c, is_cr_c;
   logic accept_c, restart_c, handshake_c, clear_c;
   logic load_lo_c, load_hi_c, full_c, bad_lo_c, bad_hi_c;

   // Accumulators hold their value through EMIT, so they drive the record bounds directly
   dec_accum #(.WIDTH(WIDTH)) u_lo (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear_c),
      .load_digit (load_lo_c),
      .digit      (in_data[3:0]),
      .value      (rng_start),
      .ovf        (lo_ovf)
   );

   dec_accum #(.WIDTH(WIDTH)) u_hi (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear_c),
      .load_digit (load_hi_c),
      .digit      (in_data[3:0]),
      .value      (rng_end),
      .ovf        (hi_ovf)
   );

   assign rng_index = count;

   // Byte classification and the legal-byte tests for each parse state
   always_comb begin
      is_digit_c  = (in_data >= CH_0) && (in_data <= CH_9);
      is_dash_c   = (in_data == CH_DASH);
      is_lf_c     = (in_data == CH_LF);
      is_cr_c     = (in_data == CH_CR);
      accept_c    = in_valid && in_ready;
      restart_c   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
      handshake_c = (state == EMIT) && rng_ready;
      clear_c     = restart_c || handshake_c;
      load_lo_c   = accept_c && (state == P_LO) && is_digit_c;
      load_hi_c   = accept_c && (state == P_HI) && is_digit_c;
      full_c      = (count == CNT_W'(MAX_RANGES));
      bad_lo_c    = lo_ovf || (accept_c && !is_digit_c && !is_cr_c
                               && !(is_dash_c && digit_seen) && !(is_lf_c && !digit_seen));
      bad_hi_c    = hi_ovf || (accept_c && !is_digit_c && !is_cr_c
                               && !(is_lf_c && digit_seen && !full_c));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         rng_valid  <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         count      <= '0;
         digit_seen <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (restart_c) begin
                  state      <= P_LO;
                  in_ready   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  count      <= '0;
                  digit_seen <= 1'b0;
               end
            end
            P_LO: begin
               if (bad_lo_c) begin
                  state    <= ERR;
                  in_ready <= 1'b0;
                  error    <= 1'b1;
               end else if (accept_c) begin
                  if (is_digit_c) begin
                     digit_seen <= 1'b1;
                  end else if (is_dash_c) begin
                     state      <= P_HI;
                     digit_seen <= 1'b0;
                  end else if (is_lf_c) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end
            P_HI: begin
               if (bad_hi_c) begin
                  state    <= ERR;
                  in_ready <= 1'b0;
                  error    <= 1'b1;
               end else if (accept_c) begin
                  if (is_digit_c) begin
                     digit_seen <= 1'b1;
                  end else if (is_lf_c) begin
                     state     <= EMIT;
                     in_ready  <= 1'b0;
                     rng_valid <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (rng_ready) begin
                  state      <= P_LO;
                  rng_valid  <= 1'b0;
                  in_ready   <= 1'b1;
                  count      <= count + 1'b1;
                  digit_seen <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               rng_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_day_5_range_loader.sv
// Directed bench for day_5_range_loader: instance 0 uses defaults, instance 1 has MAX_RANGES=2.
module tb_day_5_range_loader;
   import day5_pkg::*;

   localparam int unsigned W  = 50;
   localparam int unsigned CW = 8;

   typedef struct {
      logic [W-1:0]  s;
      logic [W-1:0]  e;
      logic [CW-1:0] idx;
   } rec_t;

   logic          clk;
   logic          rst;
   logic          start     [2];
   logic          in_valid  [2];
   logic [7:0]    in_data   [2];
   logic          in_ready  [2];
   logic          rng_valid [2];
   logic [W-1:0]  rng_start [2];
   logic [W-1:0]  rng_end   [2];
   logic [CW-1:0] rng_index [2];
   logic          rng_ready [2];
   logic          done      [2];
   logic          error     [2];
   logic [CW-1:0] count     [2];

   rec_t recs0[$];
   rec_t recs1[$];
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   day_5_range_loader u_a (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .rng_valid(rng_valid[0]), .rng_start(rng_start[0]),
      .rng_end(rng_end[0]), .rng_index(rng_index[0]), .rng_ready(rng_ready[0]),
      .done(done[0]), .error(error[0]), .count(count[0])
   );

   day_5_range_loader #(.MAX_RANGES(2)) u_b (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .rng_valid(rng_valid[1]), .rng_start(rng_start[1]),
      .rng_end(rng_end[1]), .rng_index(rng_index[1]), .rng_ready(rng_ready[1]),
      .done(done[1]), .error(error[1]), .count(count[1])
   );

   // Record every handshake; inputs only change just after posedge, so negedge is stable
   always @(negedge clk) begin
      rec_t r;
      if (rng_valid[0] && rng_ready[0]) begin
         r.s = rng_start[0]; r.e = rng_end[0]; r.idx = rng_index[0];
         recs0.push_back(r);
      end
      if (rng_valid[1] && rng_ready[1]) begin
         r.s = rng_start[1]; r.e = rng_end[1]; r.idx = rng_index[1];
         recs1.push_back(r);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start(input int sel);
      start[sel] = 1'b1;
      step();
      start[sel] = 1'b0;
   endtask

   // Present each byte until accepted; returns just after the edge that took the last byte
   task automatic send_bytes(input string s, input int sel);
      int   waited;
      logic acc;
      for (int i = 0; i < s.len(); i++) begin
         in_valid[sel] = 1'b1;
         in_data[sel]  = s[i];
         waited = 0;
         acc    = 1'b0;
         while (!acc && waited < 20) begin
            @(negedge clk);
            acc = in_ready[sel];
            step();
            waited++;
         end
         if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: byte %0d of \"%s\" not accepted, in_ready=%0b want 1", i, s, in_ready[sel]);
            in_valid[sel] = 1'b0;
            return;
         end
      end
      in_valid[sel] = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({in_ready[k], rng_valid[k], done[k], error[k]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags[%0d]: got ready/valid/done/err=%b want 0000", k,
                     {in_ready[k], rng_valid[k], done[k], error[k]});
         end
         checks++;
         if (count[k] !== 8'd0) begin
            errors++; $display("FAIL reset_count[%0d]: got %0d want 0", k, count[k]);
         end
      end
      step();
   endtask

   task automatic test_basic();
      recs0.delete();
      rng_ready[0] = 1'b1;
      pulse_start(0);
      send_bytes("3-5\n10-14\n\n", 0);
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b want 1", done[0]); end
      checks++;
      if (count[0] !== 8'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", count[0]); end
      checks++;
      if (error[0] !== 1'b0) begin errors++; $display("FAIL basic_error: got %0b want 0", error[0]); end
      checks++;
      if (recs0.size() != 2) begin
         errors++; $display("FAIL basic_nrec: got %0d want 2", recs0.size());
      end else begin
         checks++;
         if (recs0[0].s !== 50'd3 || recs0[0].e !== 50'd5 || recs0[0].idx !== 8'd0) begin
            errors++;
            $display("FAIL basic_rec0: got (%0d,%0d,%0d) want (3,5,0)", recs0[0].s, recs0[0].e, recs0[0].idx);
         end
         checks++;
         if (recs0[1].s !== 50'd10 || recs0[1].e !== 50'd14 || recs0[1].idx !== 8'd1) begin
            errors++;
            $display("FAIL basic_rec1: got (%0d,%0d,%0d) want (10,14,1)", recs0[1].s, recs0[1].e, recs0[1].idx);
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      recs0.delete();
      rng_ready[0] = 1'b0;
      pulse_start(0);
      send_bytes("12-18\n", 0);
      // A digit held on the input while stalled must not disturb the record
      in_valid[0] = 1'b1;
      in_data[0]  = "9";
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (rng_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_flags c%0d: got valid=%0b ready=%0b want 1/0", c, rng_valid[0], in_ready[0]);
         end
         checks++;
         if (rng_start[0] !== 50'd12 || rng_end[0] !== 50'd18 || rng_index[0] !== 8'd0) begin
            errors++;
            $display("FAIL bp_hold_data c%0d: got (%0d,%0d,%0d) want (12,18,0)", c, rng_start[0], rng_end[0], rng_index[0]);
         end
         step();
      end
      in_valid[0]  = 1'b0;
      rng_ready[0] = 1'b1;
      step();
      send_bytes("\n", 0);
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b1 || count[0] !== 8'd1) begin
         errors++; $display("FAIL bp_done: got done=%0b count=%0d want 1/1", done[0], count[0]);
      end
      checks++;
      if (recs0.size() != 1) begin
         errors++; $display("FAIL bp_nrec: got %0d want 1", recs0.size());
      end else if (recs0[0].s !== 50'd12 || recs0[0].e !== 50'd18 || recs0[0].idx !== 8'd0) begin
         errors++;
         $display("FAIL bp_rec: got (%0d,%0d,%0d) want (12,18,0)", recs0[0].s, recs0[0].e, recs0[0].idx);
      end
      step();
   endtask

   task automatic test_crlf_large();
      recs0.delete();
      rng_ready[0] = 1'b1;
      pulse_start(0);
      send_bytes("562949953421311-562949953421312\r\n\r\n", 0);
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b1 || error[0] !== 1'b0 || count[0] !== 8'd1) begin
         errors++;
         $display("FAIL crlf_status: got done=%0b err=%0b count=%0d want 1/0/1", done[0], error[0], count[0]);
      end
      checks++;
      if (recs0.size() != 1) begin
         errors++; $display("FAIL crlf_nrec: got %0d want 1", recs0.size());
      end else if (recs0[0].s !== 50'd562949953421311 || recs0[0].e !== 50'd562949953421312) begin
         errors++;
         $display("FAIL crlf_rec: got (%0d,%0d) want (562949953421311,562949953421312)", recs0[0].s, recs0[0].e);
      end
      step();
   endtask

   task automatic test_overflow();
      recs0.delete();
      rng_ready[0] = 1'b1;
      pulse_start(0);
      send_bytes("1125899906842624-", 0);
      @(negedge clk);
      checks++;
      if (error[0] !== 1'b1) begin errors++; $display("FAIL ovf_error: got %0b want 1", error[0]); end
      step();
      in_valid[0] = 1'b1;
      in_data[0]  = "1";
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready[0] !== 1'b0 || rng_valid[0] !== 1'b0 || error[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold c%0d: got ready=%0b valid=%0b err=%0b want 0/0/1", c, in_ready[0], rng_valid[0], error[0]);
         end
         step();
      end
      in_valid[0] = 1'b0;
      checks++;
      if (recs0.size() != 0) begin errors++; $display("FAIL ovf_nrec: got %0d want 0", recs0.size()); end
   endtask

   task automatic test_malformed();
      rng_ready[0] = 1'b1;
      pulse_start(0);
      send_bytes("7x", 0);
      @(negedge clk);
      checks++;
      if (error[0] !== 1'b1) begin errors++; $display("FAIL bad_char: got err=%0b want 1", error[0]); end
      step();
      pulse_start(0);
      @(negedge clk);
      checks++;
      if (error[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         errors++; $display("FAIL restart_clear: got err=%0b ready=%0b want 0/1", error[0], in_ready[0]);
      end
      step();
      send_bytes("-", 0);
      @(negedge clk);
      checks++;
      if (error[0] !== 1'b1) begin errors++; $display("FAIL lead_dash: got err=%0b want 1", error[0]); end
      step();
      recs0.delete();
      pulse_start(0);
      send_bytes("1-2\n\n", 0);
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b1 || error[0] !== 1'b0 || count[0] !== 8'd1) begin
         errors++;
         $display("FAIL recover_status: got done=%0b err=%0b count=%0d want 1/0/1", done[0], error[0], count[0]);
      end
      checks++;
      if (recs0.size() != 1) begin
         errors++; $display("FAIL recover_nrec: got %0d want 1", recs0.size());
      end else if (recs0[0].s !== 50'd1 || recs0[0].e !== 50'd2 || recs0[0].idx !== 8'd0) begin
         errors++;
         $display("FAIL recover_rec: got (%0d,%0d,%0d) want (1,2,0)", recs0[0].s, recs0[0].e, recs0[0].idx);
      end
      step();
   endtask

   task automatic test_capacity();
      recs1.delete();
      rng_ready[1] = 1'b1;
      pulse_start(1);
      send_bytes("1-1\n2-2\n3-3\n", 1);
      @(negedge clk);
      checks++;
      if (error[1] !== 1'b1 || rng_valid[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL cap_status: got err=%0b valid=%0b ready=%0b want 1/0/0", error[1], rng_valid[1], in_ready[1]);
      end
      checks++;
      if (count[1] !== 8'd2) begin errors++; $display("FAIL cap_count: got %0d want 2", count[1]); end
      checks++;
      if (recs1.size() != 2) begin
         errors++; $display("FAIL cap_nrec: got %0d want 2", recs1.size());
      end else if (recs1[0].s !== 50'd1 || recs1[0].e !== 50'd1 || recs1[0].idx !== 8'd0 ||
                   recs1[1].s !== 50'd2 || recs1[1].e !== 50'd2 || recs1[1].idx !== 8'd1) begin
         errors++;
         $display("FAIL cap_recs: got (%0d,%0d,%0d)(%0d,%0d,%0d) want (1,1,0)(2,2,1)", recs1[0].s, recs1[0].e,
                  recs1[0].idx, recs1[1].s, recs1[1].e, recs1[1].idx);
      end
      step();
   endtask

   task automatic test_reset_hold();
      rng_ready[0] = 1'b0;
      pulse_start(0);
      send_bytes("5-6\n", 0);
      @(negedge clk);
      checks++;
      if (rng_valid[0] !== 1'b1) begin errors++; $display("FAIL rh_pre_valid: got %0b want 1", rng_valid[0]); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({rng_valid[0], in_ready[0], done[0], error[0]} !== 4'b0000 || count[0] !== 8'd0) begin
         errors++;
         $display("FAIL rh_flags: got valid/ready/done/err=%b count=%0d want 0000/0",
                  {rng_valid[0], in_ready[0], done[0], error[0]}, count[0]);
      end
      checks++;
      if (rng_start[0] !== 50'd0 || rng_end[0] !== 50'd0 || rng_index[0] !== 8'd0) begin
         errors++;
         $display("FAIL rh_data: got (%0d,%0d,%0d) want (0,0,0)", rng_start[0], rng_end[0], rng_index[0]);
      end
      checks++;
      if (u_a.state !== IDLE) begin errors++; $display("FAIL rh_state: got %0d want IDLE", u_a.state); end
      #1 rst = 1'b0;
      step();
      step();
      @(negedge clk);
      checks++;
      if (u_a.state !== IDLE || in_ready[0] !== 1'b0) begin
         errors++; $display("FAIL rh_post: got state=%0d ready=%0b want IDLE/0", u_a.state, in_ready[0]);
      end
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = 8'h00; rng_ready[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_crlf_large();
      test_overflow();
      test_malformed();
      test_capacity();
      test_reset_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
